// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared state encoding, screen and lane geometry constants
package frogger_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    DYING     = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int GRID      = 32;

  localparam int FROG_START_X = 320;
  localparam int FROG_START_Y = 448;

  localparam int NUM_LANES_DEF     = 4;
  localparam int CAR_W_DEF         = 64;
  localparam int LANE_Y_BASE_DEF   = 128;
  localparam int START_LIVES_DEF   = 3;
  localparam int DEATH_FRAMES_DEF  = 60;
  localparam int INVULN_FRAMES_DEF = 90;

  // Top Y of lane k, truncated to the 10-bit screen coordinate space
  function automatic logic [9:0] lane_y_of(input int base, input int grid, input int k);
    return 10'(base + k * grid);
  endfunction

endpackage

// File: rtl/frog_lane_overlap.sv
// rtl/frog_lane_overlap.sv - combinational frog-versus-car overlap test for one lane
module frog_lane_overlap #(
  parameter int GRID  = 32,
  parameter int CAR_W = 64
) (
  input  logic [9:0] frog_x,
  input  logic [9:0] frog_y,
  input  logic [9:0] car_x,
  input  logic [9:0] lane_y,
  output logic       hit
);

  // Right edges are formed in 11 bits so objects near X=1023 do not wrap
  logic [10:0] frog_end;
  logic [10:0] car_end;

  assign frog_end = {1'b0, frog_x} + 11'(GRID);
  assign car_end  = {1'b0, car_x} + 11'(CAR_W);

  assign hit = (frog_y == lane_y)
            && ({1'b0, frog_x} < car_end)
            && ({1'b0, car_x} < frog_end);

endmodule

// File: rtl/frog_hazard_ctrl.sv
// rtl/frog_hazard_ctrl.sv - per-frame collision, death/respawn, lives, score and game-over control (FROG_INVULN_EN adds post-respawn invulnerability)
module frog_hazard_ctrl #(
  parameter int NUM_LANES     = frogger_pkg::NUM_LANES_DEF,
  parameter int GRID          = frogger_pkg::GRID,
  parameter int CAR_W         = frogger_pkg::CAR_W_DEF,
  parameter int LANE_Y_BASE   = frogger_pkg::LANE_Y_BASE_DEF,
  parameter int START_LIVES   = frogger_pkg::START_LIVES_DEF,
  parameter int DEATH_FRAMES  = frogger_pkg::DEATH_FRAMES_DEF,
  parameter int INVULN_FRAMES = frogger_pkg::INVULN_FRAMES_DEF
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Frame_Tick,
  input  logic                    i_Start,
  input  logic [9:0]              i_Frog_x,
  input  logic [9:0]              i_Frog_y,
  input  logic [3:0]              i_Level,
  input  logic [NUM_LANES*10-1:0] i_Car_x,
  output logic                    o_Freeze,
  output logic                    o_Respawn,
  output logic [2:0]              o_Lives,
  output logic [7:0]              o_Score,
  output logic [1:0]              o_State,
  output logic                    o_Game_Over,
  output logic                    o_Blink
);

  import frogger_pkg::*;

  state_t            state;
  state_t            next_state;
  logic [NUM_LANES-1:0] hit_vec;
  logic              any_hit;
  logic              hit_armed;
  logic [7:0]        death_cnt;
  logic [2:0]        lives_q;
  logic [7:0]        score_q;
  logic [3:0]        level_q;
  logic              freeze_q;
  logic              restart;
  logic              take_hit;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      localparam logic [9:0] lane_y_c = lane_y_of(LANE_Y_BASE, GRID, k);
      frog_lane_overlap #(
        .GRID  (GRID),
        .CAR_W (CAR_W)
      ) u_overlap (
        .frog_x (i_Frog_x),
        .frog_y (i_Frog_y),
        .car_x  (i_Car_x[10*k +: 10]),
        .lane_y (lane_y_c),
        .hit    (hit_vec[k])
      );
    end
  endgenerate

  assign any_hit = |hit_vec;

`ifdef FROG_INVULN_EN
  logic [7:0] inv_cnt;
  logic [2:0] blink_div;
  logic       blink_q;

  // Grace counter armed as RESPAWN hands back to PLAY; blink flips every eighth tick while it runs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      inv_cnt   <= '0;
      blink_div <= '0;
      blink_q   <= 1'b0;
    end else if (state == RESPAWN) begin
      inv_cnt   <= 8'(INVULN_FRAMES);
      blink_div <= '0;
      blink_q   <= 1'b1;
    end else if (i_Frame_Tick && (inv_cnt != '0)) begin
      inv_cnt   <= inv_cnt - 8'd1;
      blink_div <= blink_div + 3'd1;
      if (blink_div == 3'd7) begin
        blink_q <= ~blink_q;
      end
    end
  end

  assign hit_armed = any_hit && (inv_cnt == '0);
  assign o_Blink   = blink_q && (inv_cnt != '0);
`else
  logic unused_invuln;
  assign unused_invuln = ^8'(INVULN_FRAMES);
  assign hit_armed     = any_hit;
  assign o_Blink       = 1'b0;
`endif

  assign take_hit = (state == PLAY) && i_Frame_Tick && hit_armed;
  assign restart  = (state == GAME_OVER) && i_Start;

  // Next-state decode; collisions and the death timer only advance on frame ticks
  always_comb begin
    next_state = state;
    case (state)
      PLAY: begin
        if (take_hit) next_state = DYING;
      end
      DYING: begin
        if (i_Frame_Tick && (death_cnt == '0)) begin
          next_state = (lives_q == '0) ? GAME_OVER : RESPAWN;
        end
      end
      RESPAWN: begin
        next_state = PLAY;
      end
      GAME_OVER: begin
        if (i_Start) next_state = RESPAWN;
      end
      default: begin
        next_state = PLAY;
      end
    endcase
  end

  // State register; freeze covers every non-PLAY cycle plus the first PLAY cycle after one
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= PLAY;
      freeze_q <= 1'b0;
    end else begin
      state    <= next_state;
      freeze_q <= (state != PLAY) || (next_state != PLAY);
    end
  end

  // Death timer loads on the fatal tick and counts frames down while dying
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      death_cnt <= '0;
    end else if (take_hit) begin
      death_cnt <= 8'(DEATH_FRAMES - 1);
    end else if ((state == DYING) && i_Frame_Tick && (death_cnt != '0)) begin
      death_cnt <= death_cnt - 8'd1;
    end
  end

  // Lives drop on each hit and refill on restart
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      lives_q <= 3'(START_LIVES);
    end else if (restart) begin
      lives_q <= 3'(START_LIVES);
    end else if (take_hit && (lives_q != '0)) begin
      lives_q <= lives_q - 3'd1;
    end
  end

  // Score counts single-step level advances (including 15 to 0), in every state
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      level_q <= i_Level;
      score_q <= '0;
    end else if (restart) begin
      level_q <= i_Level;
      score_q <= '0;
    end else if (i_Level != level_q) begin
      level_q <= i_Level;
      if ((i_Level == level_q + 4'd1) && (score_q != 8'hFF)) begin
        score_q <= score_q + 8'd1;
      end
    end
  end

  assign o_Freeze    = freeze_q;
  assign o_Respawn   = (state == RESPAWN);
  assign o_Game_Over = (state == GAME_OVER);
  assign o_State     = state;
  assign o_Lives     = lives_q;
  assign o_Score     = score_q;

endmodule

// File: tb/tb_frog_hazard_ctrl.sv
// tb/tb_frog_hazard_ctrl.sv - directed self-checking bench for frog_hazard_ctrl
module tb_frog_hazard_ctrl;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Frame_Tick = 1'b0;
  logic        i_Start = 1'b0;
  logic [9:0]  i_Frog_x = 10'd320;
  logic [9:0]  i_Frog_y = 10'd448;
  logic [3:0]  i_Level = 4'd0;
  logic [39:0] i_Car_x = '0;
  logic        o_Freeze;
  logic        o_Respawn;
  logic [2:0]  o_Lives;
  logic [7:0]  o_Score;
  logic [1:0]  o_State;
  logic        o_Game_Over;
  logic        o_Blink;

  int n_cmp = 0;
  int n_bad = 0;

  frog_hazard_ctrl dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Frame_Tick (i_Frame_Tick),
    .i_Start      (i_Start),
    .i_Frog_x     (i_Frog_x),
    .i_Frog_y     (i_Frog_y),
    .i_Level      (i_Level),
    .i_Car_x      (i_Car_x),
    .o_Freeze     (o_Freeze),
    .o_Respawn    (o_Respawn),
    .o_Lives      (o_Lives),
    .o_Score      (o_Score),
    .o_State      (o_State),
    .o_Game_Over  (o_Game_Over),
    .o_Blink      (o_Blink)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step(input logic tk);
    i_Frame_Tick = tk;
    @(posedge i_Clk);
    #1;
    i_Frame_Tick = 1'b0;
  endtask

  task automatic do_reset();
    i_Car_x  = '0;
    i_Frog_x = 10'd320;
    i_Frog_y = 10'd448;
    i_Start  = 1'b0;
    i_Reset  = 1'b1;
    step(1'b0);
    i_Reset  = 1'b0;
  endtask

  // frog on lane 1 under car 1, one fatal tick, then clear and run 60 death ticks
  task automatic die_full();
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd300;
    step(1'b1);
    i_Car_x[19:10] = 10'd0;
    i_Frog_y       = 10'd448;
    for (int i = 0; i < 60; i++) step(1'b1);
  endtask

  task automatic test_reset();
    i_Level = 4'd0;
    do_reset();
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", o_State); end
    n_cmp++; if (o_Lives !== 3'd3) begin n_bad++; $display("FAIL reset_lives got %0d want 3", o_Lives); end
    n_cmp++; if (o_Score !== 8'd0) begin n_bad++; $display("FAIL reset_score got %0d want 0", o_Score); end
    n_cmp++; if (o_Freeze !== 1'b0) begin n_bad++; $display("FAIL reset_freeze got %0b want 0", o_Freeze); end
    n_cmp++; if (o_Respawn !== 1'b0) begin n_bad++; $display("FAIL reset_respawn got %0b want 0", o_Respawn); end
    n_cmp++; if (o_Game_Over !== 1'b0) begin n_bad++; $display("FAIL reset_gameover got %0b want 0", o_Game_Over); end
    n_cmp++; if (o_Blink !== 1'b0) begin n_bad++; $display("FAIL reset_blink got %0b want 0", o_Blink); end
  endtask

  task automatic test_hit_and_respawn();
    do_reset();
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd300;
    step(1'b0);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL hit_no_tick got %0d want 0", o_State); end
    step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL hit_state got %0d want 1", o_State); end
    n_cmp++; if (o_Lives !== 3'd2) begin n_bad++; $display("FAIL hit_lives got %0d want 2", o_Lives); end
    n_cmp++; if (o_Freeze !== 1'b1) begin n_bad++; $display("FAIL hit_freeze got %0b want 1", o_Freeze); end
    i_Car_x[19:10] = 10'd0;
    i_Frog_y       = 10'd448;
    for (int i = 0; i < 59; i++) step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL dying_59 got %0d want 1", o_State); end
    step(1'b1);
    n_cmp++; if (o_State !== 2'd2) begin n_bad++; $display("FAIL respawn_state got %0d want 2", o_State); end
    n_cmp++; if (o_Respawn !== 1'b1) begin n_bad++; $display("FAIL respawn_pulse got %0b want 1", o_Respawn); end
    n_cmp++; if (o_Freeze !== 1'b1) begin n_bad++; $display("FAIL respawn_freeze got %0b want 1", o_Freeze); end
    step(1'b0);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL after_respawn_state got %0d want 0", o_State); end
    n_cmp++; if (o_Respawn !== 1'b0) begin n_bad++; $display("FAIL after_respawn_pulse got %0b want 0", o_Respawn); end
    n_cmp++; if (o_Freeze !== 1'b1) begin n_bad++; $display("FAIL first_play_freeze got %0b want 1", o_Freeze); end
    step(1'b0);
    n_cmp++; if (o_Freeze !== 1'b0) begin n_bad++; $display("FAIL play_freeze got %0b want 0", o_Freeze); end
    n_cmp++; if (o_Lives !== 3'd2) begin n_bad++; $display("FAIL play_lives got %0d want 2", o_Lives); end
  endtask

  task automatic test_miss();
    do_reset();
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd352;
    step(1'b1);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL miss_right_edge got %0d want 0", o_State); end
    i_Car_x[19:10] = 10'd256;
    step(1'b1);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL miss_left_edge got %0d want 0", o_State); end
    i_Frog_y       = 10'd176;
    i_Car_x[19:10] = 10'd300;
    step(1'b1);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL miss_off_lane got %0d want 0", o_State); end
    n_cmp++; if (o_Lives !== 3'd3) begin n_bad++; $display("FAIL miss_lives got %0d want 3", o_Lives); end
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd351;
    step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL hit_one_pixel got %0d want 1", o_State); end
  endtask

  task automatic test_wrap();
    do_reset();
    i_Frog_x      = 10'd1000;
    i_Frog_y      = 10'd128;
    i_Car_x[9:0]  = 10'd990;
    step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL hit_no_wrap got %0d want 1", o_State); end
    do_reset();
    i_Frog_y      = 10'd224;
    i_Car_x[39:30] = 10'd300;
    step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL hit_lane3 got %0d want 1", o_State); end
  endtask

  task automatic test_game_over();
    i_Level = 4'd0;
    do_reset();
    i_Level = 4'd1;
    step(1'b0);
    n_cmp++; if (o_Score !== 8'd1) begin n_bad++; $display("FAIL go_pre_score got %0d want 1", o_Score); end
    die_full();
    step(1'b0);
    i_Start = 1'b1;
    step(1'b0);
    i_Start = 1'b0;
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL start_in_play got %0d want 0", o_State); end
    n_cmp++; if (o_Lives !== 3'd2) begin n_bad++; $display("FAIL start_in_play_lives got %0d want 2", o_Lives); end
    die_full();
    step(1'b0);
    die_full();
    n_cmp++; if (o_State !== 2'd3) begin n_bad++; $display("FAIL go_state got %0d want 3", o_State); end
    n_cmp++; if (o_Lives !== 3'd0) begin n_bad++; $display("FAIL go_lives got %0d want 0", o_Lives); end
    n_cmp++; if (o_Game_Over !== 1'b1) begin n_bad++; $display("FAIL go_flag got %0b want 1", o_Game_Over); end
    n_cmp++; if (o_Freeze !== 1'b1) begin n_bad++; $display("FAIL go_freeze got %0b want 1", o_Freeze); end
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd300;
    step(1'b1);
    i_Car_x[19:10] = 10'd0;
    i_Frog_y       = 10'd448;
    n_cmp++; if (o_State !== 2'd3) begin n_bad++; $display("FAIL go_ignore_hit got %0d want 3", o_State); end
    i_Start = 1'b1;
    step(1'b0);
    i_Start = 1'b0;
    n_cmp++; if (o_State !== 2'd2) begin n_bad++; $display("FAIL restart_state got %0d want 2", o_State); end
    n_cmp++; if (o_Respawn !== 1'b1) begin n_bad++; $display("FAIL restart_respawn got %0b want 1", o_Respawn); end
    n_cmp++; if (o_Lives !== 3'd3) begin n_bad++; $display("FAIL restart_lives got %0d want 3", o_Lives); end
    n_cmp++; if (o_Score !== 8'd0) begin n_bad++; $display("FAIL restart_score got %0d want 0", o_Score); end
    step(1'b0);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL restart_play got %0d want 0", o_State); end
  endtask

  task automatic test_score();
    i_Level = 4'd1;
    do_reset();
    n_cmp++; if (o_Score !== 8'd0) begin n_bad++; $display("FAIL score_reset got %0d want 0", o_Score); end
    i_Level = 4'd2; step(1'b0);
    i_Level = 4'd3; step(1'b0);
    n_cmp++; if (o_Score !== 8'd2) begin n_bad++; $display("FAIL score_steps got %0d want 2", o_Score); end
    i_Level = 4'd5; step(1'b0);
    n_cmp++; if (o_Score !== 8'd2) begin n_bad++; $display("FAIL score_jump got %0d want 2", o_Score); end
    i_Level = 4'd15; step(1'b0);
    i_Level = 4'd0; step(1'b0);
    n_cmp++; if (o_Score !== 8'd3) begin n_bad++; $display("FAIL score_wrap got %0d want 3", o_Score); end
    for (int i = 0; i < 252; i++) begin
      i_Level = i_Level + 4'd1;
      step(1'b0);
    end
    n_cmp++; if (o_Score !== 8'd255) begin n_bad++; $display("FAIL score_top got %0d want 255", o_Score); end
    i_Level = i_Level + 4'd1;
    step(1'b0);
    n_cmp++; if (o_Score !== 8'd255) begin n_bad++; $display("FAIL score_sat got %0d want 255", o_Score); end
  endtask

  task automatic test_back_to_back();
    i_Level = 4'd0;
    do_reset();
    i_Level        = 4'd1;
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd300;
    step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL b2b_state got %0d want 1", o_State); end
    n_cmp++; if (o_Lives !== 3'd2) begin n_bad++; $display("FAIL b2b_lives got %0d want 2", o_Lives); end
    n_cmp++; if (o_Score !== 8'd1) begin n_bad++; $display("FAIL b2b_score got %0d want 1", o_Score); end
  endtask

  task automatic test_reset_mid_dying();
    i_Level = 4'd0;
    do_reset();
    i_Level        = 4'd1;
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd300;
    step(1'b1);
    i_Car_x[19:10] = 10'd0;
    i_Frog_y       = 10'd448;
    for (int i = 0; i < 29; i++) step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL mid_dying_state got %0d want 1", o_State); end
    i_Level = 4'd7;
    i_Reset = 1'b1;
    step(1'b1);
    i_Reset = 1'b0;
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL mid_reset_state got %0d want 0", o_State); end
    n_cmp++; if (o_Lives !== 3'd3) begin n_bad++; $display("FAIL mid_reset_lives got %0d want 3", o_Lives); end
    n_cmp++; if (o_Score !== 8'd0) begin n_bad++; $display("FAIL mid_reset_score got %0d want 0", o_Score); end
    n_cmp++; if (o_Freeze !== 1'b0) begin n_bad++; $display("FAIL mid_reset_freeze got %0b want 0", o_Freeze); end
    n_cmp++; if (o_Respawn !== 1'b0) begin n_bad++; $display("FAIL mid_reset_respawn got %0b want 0", o_Respawn); end
    step(1'b0);
    n_cmp++; if (o_Score !== 8'd0) begin n_bad++; $display("FAIL mid_reset_level_load got %0d want 0", o_Score); end
  endtask

  task automatic test_post_respawn();
    do_reset();
    die_full();
    step(1'b0);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL pr_play got %0d want 0", o_State); end
    i_Frog_y       = 10'd160;
    i_Car_x[19:10] = 10'd300;
`ifdef FROG_INVULN_EN
    n_cmp++; if (o_Blink !== 1'b1) begin n_bad++; $display("FAIL inv_blink_start got %0b want 1", o_Blink); end
    for (int i = 0; i < 7; i++) step(1'b1);
    n_cmp++; if (o_Blink !== 1'b1) begin n_bad++; $display("FAIL inv_blink_7 got %0b want 1", o_Blink); end
    step(1'b1);
    n_cmp++; if (o_Blink !== 1'b0) begin n_bad++; $display("FAIL inv_blink_8 got %0b want 0", o_Blink); end
    for (int i = 0; i < 8; i++) step(1'b1);
    n_cmp++; if (o_Blink !== 1'b1) begin n_bad++; $display("FAIL inv_blink_16 got %0b want 1", o_Blink); end
    for (int i = 0; i < 74; i++) step(1'b1);
    n_cmp++; if (o_State !== 2'd0) begin n_bad++; $display("FAIL inv_ignored_90 got %0d want 0", o_State); end
    n_cmp++; if (o_Blink !== 1'b0) begin n_bad++; $display("FAIL inv_blink_end got %0b want 0", o_Blink); end
    step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL inv_hit_91 got %0d want 1", o_State); end
`else
    step(1'b1);
    n_cmp++; if (o_State !== 2'd1) begin n_bad++; $display("FAIL first_tick_hit got %0d want 1", o_State); end
    n_cmp++; if (o_Lives !== 3'd1) begin n_bad++; $display("FAIL first_tick_lives got %0d want 1", o_Lives); end
    n_cmp++; if (o_Blink !== 1'b0) begin n_bad++; $display("FAIL blink_tied got %0b want 0", o_Blink); end
`endif
    i_Car_x[19:10] = 10'd0;
    i_Frog_y       = 10'd448;
  endtask

  initial begin
    test_reset();
    test_hit_and_respawn();
    test_miss();
    test_wrap();
    test_game_over();
    test_score();
    test_back_to_back();
    test_reset_mid_dying();
    test_post_respawn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frog_hazard_ctrl.md
Name: frog_hazard_ctrl

Overview:
- Sits directly downstream of the frog movement stage.
- Consumes frog position and level, plus per-lane car X positions from the traffic stage.
- Once per video frame, checks whether the frog overlaps a car, then manages death, respawn, lives, score and game-over.
- Drives freeze/respawn controls back to the movement stage and status to the HUD/VGA renderer.

Parameters:
- NUM_LANES, 4, number of road lanes, one car per lane
- GRID, 32, cell size in pixels; also the frog width
- CAR_W, 64, car width in pixels
- LANE_Y_BASE, 128, Y of lane 0; lane k sits at Y = LANE_Y_BASE + k*GRID
- START_LIVES, 3, lives loaded at reset and on restart (max 7)
- DEATH_FRAMES, 60, frames spent in DYING
- INVULN_FRAMES, 90, post-respawn grace frames (optional feature only)

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Frame_Tick  in  1  one-cycle pulse per frame (start of vblank)
- i_Start  in  1  restart request, honoured only in GAME_OVER
- i_Frog_x  in  10  frog left X
- i_Frog_y  in  10  frog top Y
- i_Level  in  4  current level from the movement stage
- i_Car_x  in  NUM_LANES*10  car left X; lane k occupies bits [10k+9:10k]
- o_Freeze  out  1  movement stage must ignore switches while high
- o_Respawn  out  1  one-cycle pulse: movement stage reloads the start position
- o_Lives  out  3  remaining lives
- o_Score  out  8  levels completed, saturates at 255
- o_State  out  2  0=PLAY, 1=DYING, 2=RESPAWN, 3=GAME_OVER
- o_Game_Over  out  1  high in GAME_OVER
- o_Blink  out  1  frog blink enable for the renderer

Behaviour:
- **Reset** (i_Reset high at a clock edge): state=PLAY, o_Lives=START_LIVES, o_Score=0, o_Freeze=0, o_Respawn=0, o_Game_Over=0, o_Blink=0, frame counter=0. Level register loads i_Level, so no spurious score increment occurs. Reset overrides everything, including mid-DYING.
- **Hit test** (combinational per lane): hit_k = (i_Frog_y == LANE_Y_BASE + k*GRID) && (i_Frog_x < car_x + CAR_W) && (car_x < i_Frog_x + GRID). Sums use 11-bit arithmetic, so there is no wrap at 1023. Any hit = OR of all hit_k.
- **PLAY**:
  - Collision is sampled only on the cycle i_Frame_Tick is high.
  - On a hit: o_Lives decrements and the counter loads DEATH_FRAMES-1. Next cycle the state is DYING and o_Freeze=1, giving a registered latency of 1 cycle after the tick.
- **DYING**:
  - o_Freeze=1. The counter decrements on each i_Frame_Tick.
  - On a tick with counter==0: go to GAME_OVER if o_Lives==0, otherwise go to RESPAWN.
  - o_Freeze stays 1 until the cycle after the first PLAY cycle.
- **RESPAWN**: lasts exactly one cycle. o_Respawn=1, o_Freeze=1, then the state returns to PLAY.
- **GAME_OVER**:
  - o_Freeze=1, o_Game_Over=1. Hits are ignored.
  - i_Start: o_Lives=START_LIVES, o_Score=0, then go to RESPAWN.
- **Score**:
  - Every cycle, if i_Level != stored level, store it.
  - If the new value equals stored+1 (mod 16), increment o_Score, saturating at 255.
  - This is evaluated in every state. A hit and a level change in the same cycle are both applied.
- **i_Start**: ignored outside GAME_OVER.
- **i_Frame_Tick held high**: counts once per cycle high; the upstream stage guarantees single-cycle pulses.

Optional Feature:
- Macro: FROG_INVULN_EN.
- **Defined**:
  - On leaving RESPAWN, an invulnerability counter loads INVULN_FRAMES and decrements per frame tick.
  - While it is nonzero, hits are ignored and o_Blink toggles every 8 frame ticks.
  - o_Blink=0 when the counter is zero.
  - Reset clears the counter.
- **Undefined**: no counter; collisions are checked from the first PLAY tick; o_Blink is tied 0.

Decomposition:
- Package frogger_pkg holds:
  - state encoding constants PLAY/DYING/RESPAWN/GAME_OVER
  - screen constants H_DISPLAY=640, V_DISPLAY=480, GRID=32
  - the frog start position 320/448
  - lane geometry defaults
- One sub-module, frog_lane_overlap: purely combinational single-lane overlap check (frog x/y, car x, lane y → hit). Instantiated NUM_LANES times via generate.

Test Plan:
- **Hit detection**: reset; frog (320,160), car1 x=300, tick → DYING next cycle, o_Lives 3→2, o_Freeze=1.
- **No hit on a miss**: frog (320,160), car1 x=352 (touching edge only) or frog y=176, tick → no hit, stays PLAY.
- **Respawn timing**: after a hit, apply 60 ticks → RESPAWN for 1 cycle with o_Respawn=1, then PLAY, o_Freeze=0.
- **Game over and restart**: three hits with full death sequences → GAME_OVER, o_Lives=0, o_Game_Over=1. Pulse i_Start → o_Lives=3, o_Score=0, o_Respawn pulse.
- **Score**:
  - i_Level steps 1→2→3 → o_Score=2.
  - i_Level wraps 15→0 → increments.
  - From score 255 → holds at 255.
  - Hit and level change in the same cycle → both applied.
- **Reset mid-DYING and invulnerability**: assert i_Reset at counter=30 → PLAY, lives=3, all outputs at reset values. With FROG_INVULN_EN defined: after respawn, a hit within 90 ticks is ignored and o_Blink toggles every 8 ticks; a hit on tick 91 registers.
